// File: rtl/bsg_rr_mux_pkg.sv
// Shared types and constants for the round-robin one-hot mux arbiter.
// Packet locking is controlled by the BSG_RR_MUX_PKT_LOCK_EN macro.
package bsg_rr_mux_pkg;

    // Arbitration state: ARB picks freely; LOCK holds the grant on one requester.
    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Pointer width; a single requester still gets a 1-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned els);
        return (els <= 1) ? 1 : $clog2(els);
    endfunction

endpackage

// File: rtl/bsg_rr_pick_one_hot.sv
// Combinational rotate-priority picker: returns the first set request bit at
// or above i_ptr (wrapping to 0) as a one-hot grant plus its encoded index.
module bsg_rr_pick_one_hot
    import bsg_rr_mux_pkg::*;
#(
    parameter  int unsigned els_p = 4,
    localparam int unsigned PTR_W = ptr_width(els_p)
) (
    input  logic [els_p-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [els_p-1:0] o_grant,
    output logic [PTR_W-1:0] o_grant_idx
);

    // Scan els_p positions starting at the pointer; the first hit wins.
    always_comb begin : pick
        int unsigned idx;
        logic        found;
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        idx         = 0;
        for (int unsigned i = 0; i < els_p; i++) begin
            idx = (32'(i_ptr) + i) % els_p;
            if (!found && i_req[PTR_W'(idx)]) begin
                found                  = 1'b1;
                o_grant[PTR_W'(idx)]   = 1'b1;
                o_grant_idx            = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bsg_rr_mux_one_hot_arb.sv
// Round-robin arbiter and registered output stage sharing one width_p-bit
// channel between els_p valid/yumi requesters.
// Optional packet locking: define BSG_RR_MUX_PKT_LOCK_EN to hold the grant
// on one requester until it presents a beat with last_i set.
module bsg_rr_mux_one_hot_arb
    import bsg_rr_mux_pkg::*;
#(
    parameter int unsigned width_p = 32,
    parameter int unsigned els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   data_i,
    input  logic [els_p-1:0]           last_i,
    output logic [els_p-1:0]           yumi_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [els_p-1:0]           sel_one_hot_o,
    input  logic                       ready_i
);

    localparam int unsigned PTR_W = ptr_width(els_p);

    // Output beat register and round-robin pointer.
    logic                 r_v;
    logic [width_p-1:0]   r_data;
    logic [els_p-1:0]     r_sel;
    logic [PTR_W-1:0]     r_ptr;

    logic                 w_ld;
    logic [els_p-1:0]     w_cand;
    logic [els_p-1:0]     w_grant;
    logic [PTR_W-1:0]     w_grant_idx;
    logic [els_p-1:0]     w_yumi;
    logic                 w_any;
    logic                 w_last;
    logic [width_p-1:0]   w_data_sel;
    logic [PTR_W-1:0]     w_ptr_inc;
    logic [PTR_W-1:0]     w_ptr_next;

`ifdef BSG_RR_MUX_PKT_LOCK_EN
    state_e               r_state;
    state_e               w_state_next;
    logic [PTR_W-1:0]     r_lock_idx;
    logic [PTR_W-1:0]     w_lock_idx_next;
    logic [els_p-1:0]     w_lock_mask;
`else
    logic                 w_unused_last;
`endif

    // The output register can take a new beat when empty or being drained.
    assign w_ld = ~r_v | ready_i;

`ifdef BSG_RR_MUX_PKT_LOCK_EN
    // While locked, only the locked requester is a candidate.
    always_comb begin
        w_lock_mask              = '0;
        w_lock_mask[r_lock_idx]  = 1'b1;
        w_cand                   = v_i;
        if (r_state == LOCK) begin
            w_cand = v_i & w_lock_mask;
        end
    end
`else
    assign w_cand = v_i;
`endif

    bsg_rr_pick_one_hot #(
        .els_p        (els_p)
    ) u_pick (
        .i_req        (w_cand),
        .i_ptr        (r_ptr),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx)
    );

    // Grant becomes a consume strobe only when the beat can be loaded.
    assign w_yumi = w_grant & {els_p{w_ld & ~reset_i}};
    assign w_any  = |w_yumi;
    assign yumi_o = w_yumi;

`ifdef BSG_RR_MUX_PKT_LOCK_EN
    assign w_last = last_i[w_grant_idx];
`else
    // Without locking every beat ends its own packet.
    assign w_last        = 1'b1;
    assign w_unused_last = ^last_i;
`endif

    // One-hot AND-OR data steering; zero when nobody is granted.
    always_comb begin
        w_data_sel = '0;
        for (int unsigned k = 0; k < els_p; k++) begin
            w_data_sel = w_data_sel
                       | (data_i[k*width_p +: width_p] & {width_p{w_yumi[k]}});
        end
    end

    // Pointer value one past the granted requester, with wrap.
    assign w_ptr_inc = (w_grant_idx == PTR_W'(els_p - 1))
                     ? '0
                     : w_grant_idx + PTR_W'(1);

`ifdef BSG_RR_MUX_PKT_LOCK_EN
    // Next-state logic for the ARB/LOCK machine, pointer and lock index.
    always_comb begin
        w_state_next    = r_state;
        w_lock_idx_next = r_lock_idx;
        w_ptr_next      = r_ptr;
        if (w_any) begin
            case (r_state)
                ARB: begin
                    if (!w_last) begin
                        w_state_next    = LOCK;
                        w_lock_idx_next = w_grant_idx;
                    end else begin
                        w_ptr_next = w_ptr_inc;
                    end
                end
                LOCK: begin
                    if (w_last) begin
                        w_state_next = ARB;
                        w_ptr_next   = w_ptr_inc;
                    end
                end
                default: begin
                    w_state_next = ARB;
                end
            endcase
        end
    end

    // State and lock index registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= ARB;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lock_idx <= w_lock_idx_next;
        end
    end
`else
    // Pointer advances past every granted requester.
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_any && w_last) begin
            w_ptr_next = w_ptr_inc;
        end
    end
`endif

    // Round-robin pointer register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    // Output beat register; reloads whenever the slot is free or retiring.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_v    <= 1'b0;
            r_sel  <= '0;
            r_data <= '0;
        end else if (w_ld) begin
            r_v    <= w_any;
            r_sel  <= w_yumi;
            r_data <= w_data_sel;
        end
    end

    assign v_o           = r_v;
    assign data_o        = r_data;
    assign sel_one_hot_o = r_sel;

endmodule

// File: tb/tb_bsg_rr_mux_one_hot_arb.sv
// Scoreboard bench for bsg_rr_mux_one_hot_arb (els_p=4, width_p=32).
// Builds with or without BSG_RR_MUX_PKT_LOCK_EN; the packet case adapts.
module tb_bsg_rr_mux_one_hot_arb;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;

    typedef struct packed {
        logic [N-1:0] sel;
        logic [W-1:0] data;
    } beat_t;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [N-1:0]     v_i;
    logic [N*W-1:0]   data_i;
    logic [N-1:0]     last_i;
    logic [N-1:0]     yumi_o;
    logic             v_o;
    logic [W-1:0]     data_o;
    logic [N-1:0]     sel_one_hot_o;
    logic             ready_i;

    logic [W-1:0]     req_data [N];
    beat_t            exp_q [$];
    int               n_pass  = 0;
    int               n_total = 0;
    logic             mon_en  = 1'b0;

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < N; g++) begin : g_data
        assign data_i[g*W +: W] = req_data[g];
    end

    bsg_rr_mux_one_hot_arb #(
        .width_p       (W),
        .els_p         (N)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .v_i           (v_i),
        .data_i        (data_i),
        .last_i        (last_i),
        .yumi_o        (yumi_o),
        .v_o           (v_o),
        .data_o        (data_o),
        .sel_one_hot_o (sel_one_hot_o),
        .ready_i       (ready_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle of inputs, check yumi, and queue the expected beat.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] last, input logic rdy,
                        input logic [N-1:0] exp_y, input string name);
        @(posedge clk_i);
        #2;
        v_i     = v;
        last_i  = last;
        ready_i = rdy;
        #1;
        check({name, " yumi"}, 64'(yumi_o), 64'(exp_y));
        for (int k = 0; k < N; k++) begin
            if (exp_y[k]) exp_q.push_back({exp_y, req_data[k]});
        end
    endtask

    // Monitor: compare every presented output against the queue head.
    always @(negedge clk_i) begin
        if (mon_en && !reset_i) begin
            if (v_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected beat", 64'(1), 64'(0));
                end else begin
                    check("data_o", 64'(data_o), 64'(exp_q[0].data));
                    check("sel_one_hot_o", 64'(sel_one_hot_o), 64'(exp_q[0].sel));
                    if (ready_i) void'(exp_q.pop_front());
                end
            end else begin
                check("idle sel", 64'(sel_one_hot_o), 64'(0));
                check("idle data", 64'(data_o), 64'(0));
            end
        end
    end

    initial begin
        for (int k = 0; k < N; k++) req_data[k] = 32'hA0 + 32'(k);
        reset_i = 1'b1;
        v_i     = 4'b1111;
        last_i  = 4'b1111;
        ready_i = 1'b1;
        #1;
        check("reset v_o", 64'(v_o), 64'(0));
        check("reset data_o", 64'(data_o), 64'(0));
        check("reset sel", 64'(sel_one_hot_o), 64'(0));
        check("reset yumi", 64'(yumi_o), 64'(0));
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        reset_i = 1'b0;
        v_i     = '0;
        mon_en  = 1'b1;

        // Fairness: all valid, full throughput
        step(4'b1111, 4'b1111, 1'b1, 4'b0001, "fair0");
        step(4'b1111, 4'b1111, 1'b1, 4'b0010, "fair1");
        step(4'b1111, 4'b1111, 1'b1, 4'b0100, "fair2");
        step(4'b1111, 4'b1111, 1'b1, 4'b1000, "fair3");
        step(4'b1111, 4'b1111, 1'b1, 4'b0001, "fair4");
        step(4'b1111, 4'b1111, 1'b1, 4'b0010, "fair5");
        step(4'b1111, 4'b1111, 1'b1, 4'b0100, "fair6");

        // Wrap from ptr=3 and skip idle requesters
        step(4'b0101, 4'b1111, 1'b1, 4'b0001, "wrap");
        step(4'b0101, 4'b1111, 1'b1, 4'b0100, "skip");

        // Backpressure with a held DEADBEEF beat
        req_data[0] = 32'hDEADBEEF;
        step(4'b0001, 4'b1111, 1'b1, 4'b0001, "bp_load");
        step(4'b1111, 4'b1111, 1'b0, 4'b0000, "bp_hold1");
        step(4'b1111, 4'b1111, 1'b0, 4'b0000, "bp_hold2");
        step(4'b1111, 4'b1111, 1'b0, 4'b0000, "bp_hold3");
        step(4'b1111, 4'b1111, 1'b1, 4'b0010, "bp_release");
        req_data[0] = 32'hA0;
        step(4'b0000, 4'b1111, 1'b1, 4'b0000, "bp_drain");

        // Packet from requester 2 (last 0,0,1) with requester 1 always valid
`ifdef BSG_RR_MUX_PKT_LOCK_EN
        step(4'b0110, 4'b1011, 1'b1, 4'b0100, "pkt_b0");
        step(4'b0110, 4'b1011, 1'b1, 4'b0100, "pkt_b1");
        step(4'b0010, 4'b1011, 1'b1, 4'b0000, "pkt_stall");
        step(4'b0110, 4'b1111, 1'b1, 4'b0100, "pkt_b2");
        step(4'b0010, 4'b1111, 1'b1, 4'b0010, "pkt_r1");
        step(4'b1010, 4'b1111, 1'b1, 4'b1000, "pkt_r3");
`else
        step(4'b0110, 4'b1011, 1'b1, 4'b0100, "nolock_b0");
        step(4'b0110, 4'b1011, 1'b1, 4'b0010, "nolock_r1a");
        step(4'b0010, 4'b1011, 1'b1, 4'b0010, "nolock_r1b");
        step(4'b0110, 4'b1111, 1'b1, 4'b0100, "nolock_b2");
        step(4'b0010, 4'b1111, 1'b1, 4'b0010, "nolock_r1c");
        step(4'b1010, 4'b1111, 1'b1, 4'b1000, "nolock_r3");
`endif

        // Mid-cycle reset while a beat is held and everyone is valid
        step(4'b0001, 4'b1111, 1'b1, 4'b0001, "pre_rst");
        step(4'b1111, 4'b1111, 1'b0, 4'b0000, "pre_rst_hold");
        #3;
        reset_i = 1'b1;
        #1;
        check("midrst v_o", 64'(v_o), 64'(0));
        check("midrst data_o", 64'(data_o), 64'(0));
        check("midrst sel", 64'(sel_one_hot_o), 64'(0));
        check("midrst yumi", 64'(yumi_o), 64'(0));
        exp_q.delete();
        @(posedge clk_i);
        #2;
        reset_i = 1'b0;
        v_i     = '0;
        step(4'b1111, 4'b1111, 1'b1, 4'b0001, "post_rst_first");
        step(4'b0000, 4'b1111, 1'b1, 4'b0000, "final_drain");
        step(4'b0000, 4'b1111, 1'b1, 4'b0000, "final_idle");
        @(posedge clk_i);
        #3;
        check("queue empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
